tiny_wb_fifo_port: RTL and testbench



---
 rtl/tiny_wb_pkg.sv | 22 ++
 rtl/tiny_sync_fifo.sv | 72 +++++++
 rtl/tiny_wb_fifo_port.sv | 138 +++++++++++++
 tb/tb_tiny_wb_fifo_port.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_wb_pkg.sv
// Shared register offsets, bit positions and sizing helpers for the tiny Wishbone
// FIFO port.
package tiny_wb_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_IRQ    = 2'd3;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_IRQEN = 1;
  localparam int unsigned CTRL_FLUSH = 2;
  localparam int unsigned ST_EMPTY   = 8;
  localparam int unsigned ST_FULL    = 9;
  localparam int unsigned ST_OVF     = 10;

  // A level counter must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tiny_sync_fifo.sv
// Single-clock FIFO with a synchronous flush; pushes when full and pops when empty
// are ignored.
module tiny_sync_fifo
  import tiny_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = level_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] head_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Power-of-two depth: pointer increment wraps by truncation.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tiny_wb_fifo_port.sv
// Wishbone-classic slave with a 4-register map feeding a TX byte FIFO that drains
// over a valid/ready stream and interrupts when it runs dry.
module tiny_wb_fifo_port
  import tiny_wb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DW        = 8,
  localparam int unsigned LW       = level_width(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [DW-1:0] tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          irq_o
);

  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          en_q, en_d;
  logic          irqen_q, irqen_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic          irq_q, irq_d;

  logic          accept, wr;
  logic [1:0]    reg_sel;
  logic [31:0]   rdata;
  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          ovf_set, pend_set;
  logic          unused_bits;

  assign accept  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]) & ~ack_q;
  assign wr      = accept & wbs_we_i & wbs_sel_i[0];
  assign reg_sel = wbs_adr_i[3:2];

  assign tx_valid_o = en_q & ~fifo_empty;
  assign fifo_pop   = tx_valid_o & tx_ready_i;
  assign fifo_flush = wr & (reg_sel == REG_CTRL) & wbs_dat_i[CTRL_FLUSH];
  assign fifo_push  = wr & (reg_sel == REG_TXDATA);

  assign ovf_set  = fifo_push & fifo_full;
  // Flush overrides a same-cycle pop, so that pop never counts as draining.
  assign pend_set = fifo_pop & (fifo_level == LW'(1)) & ~fifo_flush;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i};

  tiny_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .push_i  (fifo_push),
    .data_i  (wbs_dat_i[DW-1:0]),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .head_o  (tx_data_o),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]    = en_q;
        rdata[CTRL_IRQEN] = irqen_q;
      end
      REG_STATUS: begin
        rdata[LW-1:0]   = fifo_level;
        rdata[ST_EMPTY] = fifo_empty;
        rdata[ST_FULL]  = fifo_full;
        rdata[ST_OVF]   = ovf_q;
      end
      REG_TXDATA: rdata = '0;
      REG_IRQ:    rdata[0] = pend_q;
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d   = accept;
    dat_d   = (accept && !wbs_we_i) ? rdata : '0;
    en_d    = en_q;
    irqen_d = irqen_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    irq_d   = pend_q & irqen_q;

    if (wr && reg_sel == REG_CTRL) begin
      en_d    = wbs_dat_i[CTRL_EN];
      irqen_d = wbs_dat_i[CTRL_IRQEN];
    end
    if (wr && reg_sel == REG_STATUS && wbs_dat_i[ST_OVF]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    if (wr && reg_sel == REG_IRQ && wbs_dat_i[0]) pend_d = 1'b0;
    if (pend_set) pend_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      irqen_q <= irqen_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_tiny_wb_fifo_port.sv
// Randomized self-checking bench: a queue-based model of the register map and
// stream is compared against the DUT every cycle, plus directed literal checks.
module tb_tiny_wb_fifo_port;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat_o;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [7:0]  q[$];
  logic        m_en = 0, m_irqen = 0, m_ovf = 0, m_pend = 0, m_irq = 0, m_ack = 0;
  logic [31:0] m_dat = '0;

  tiny_wb_fifo_port dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat_o),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each clock edge, using pre-edge state throughout.
  always @(posedge clk or negedge rst_n) begin : model
    logic        acc, wr, full, empty, pop, flush, push, ovf_set, pend_set;
    logic [1:0]  rs;
    logic [31:0] rd;
    if (!rst_n) begin
      q.delete();
      m_en = 0; m_irqen = 0; m_ovf = 0; m_pend = 0; m_irq = 0; m_ack = 0; m_dat = '0;
    end else begin
      acc   = cyc && stb && (adr[31:4] == BASE[31:4]) && !m_ack;
      wr    = acc && we && sel[0];
      rs    = adr[3:2];
      full  = (q.size() == 8);
      empty = (q.size() == 0);
      pop   = m_en && !empty && tx_ready;
      flush = wr && rs == 2'd0 && wdat[2];
      push  = wr && rs == 2'd2;
      rd = 0;
      case (rs)
        2'd0: rd = {30'd0, m_irqen, m_en};
        2'd1: rd = 32'(q.size()) | (32'(empty) << 8) | (32'(full) << 9) | (32'(m_ovf) << 10);
        2'd2: rd = 0;
        2'd3: rd = {31'd0, m_pend};
      endcase
      ovf_set = 0;
      pend_set = 0;
      m_irq = m_pend && m_irqen;
      m_dat = (acc && !we) ? rd : 32'd0;
      m_ack = acc;
      if (flush) q.delete();
      else begin
        if (pop) begin
          void'(q.pop_front());
          if (q.size() == 0) pend_set = 1;
        end
        if (push) begin
          if (full) ovf_set = 1;
          else q.push_back(wdat[7:0]);
        end
      end
      if (wr && rs == 2'd0) begin m_en = wdat[0]; m_irqen = wdat[1]; end
      if (wr && rs == 2'd1 && wdat[10]) m_ovf = 0;
      if (ovf_set) m_ovf = 1;
      if (wr && rs == 2'd3 && wdat[0]) m_pend = 0;
      if (pend_set) m_pend = 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ack", 32'(ack), 32'(m_ack));
    chk("dat_o", rdat_o, m_dat);
    chk("tx_valid", 32'(tx_valid), 32'(m_en && q.size() > 0));
    if (tx_valid && q.size() > 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
    chk("irq", 32'(irq), 32'(m_irq));
  end

  // Starts #1 after a posedge, ends #1 after a posedge.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat);
    logic got = 0;
    rd = '0;
    lat = 0;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack) begin
        got = 1;
        rd = rdat_o;
        lat = i + 1;
      end
    end
    if (!got) chk("ack_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int l;
    wb_xfer(1'b1, a, d, 4'hF, r, l);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] r);
    int l;
    wb_xfer(1'b0, a, 32'd0, 4'hF, r, l);
  endtask

  initial begin
    logic [31:0] r;
    int lat, nack;

    // 1: reset and first read
    #12 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_valid", 32'(tx_valid), 0);
    wb_xfer(1'b0, BASE + 4, 0, 4'hF, r, lat);
    chk("status_reset", r, 32'h0000_0100);
    chk("ack_latency", 32'(lat), 1);

    // 2: queue three bytes, then drain them back-to-back
    wr_reg(BASE + 0, 1);
    wr_reg(BASE + 8, 32'hA1);
    wr_reg(BASE + 8, 32'hB2);
    wr_reg(BASE + 8, 32'hC3);
    rd_reg(BASE + 4, r);
    chk("status_lvl3", r, 32'h0000_0003);
    chk("head_valid", 32'(tx_valid), 1);
    chk("head_a1", 32'(tx_data), 32'hA1);
    tx_ready = 1;
    @(negedge clk); chk("drain_a1", 32'(tx_data), 32'hA1);
    @(negedge clk); chk("drain_b2", 32'(tx_data), 32'hB2);
    @(negedge clk); chk("drain_c3", 32'(tx_data), 32'hC3);
    @(negedge clk); chk("drain_done", 32'(tx_valid), 0);
    @(posedge clk); #1 tx_ready = 0;

    // 3: overflow with enable off
    wr_reg(BASE + 0, 0);
    for (int i = 0; i < 9; i++) wr_reg(BASE + 8, 32'(8'h10 + i));
    rd_reg(BASE + 4, r);
    chk("status_ovf", r, 32'h0000_0608);
    wr_reg(BASE + 4, 32'h400);
    rd_reg(BASE + 4, r);
    chk("status_ovf_clr", r, 32'h0000_0208);
    wr_reg(BASE + 0, 4);

    // 4: drain-empty interrupt and set-beats-clear
    wr_reg(BASE + 12, 1);
    wr_reg(BASE + 0, 3);
    wr_reg(BASE + 8, 32'h55);
    tx_ready = 1;
    @(posedge clk); #1 tx_ready = 0;
    chk("irq_not_yet", 32'(irq), 0);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq), 1);
    rd_reg(BASE + 12, r);
    chk("pending_set", r, 1);
    wr_reg(BASE + 12, 1);
    chk("irq_cleared", 32'(irq), 0);
    wr_reg(BASE + 8, 32'h66);
    tx_ready = 1;
    wr_reg(BASE + 12, 1);
    tx_ready = 0;
    rd_reg(BASE + 12, r);
    chk("pending_set_wins", r, 1);

    // 5: flush colliding with a pop; out-of-window access
    for (int i = 0; i < 5; i++) wr_reg(BASE + 8, 32'(8'h70 + i));
    tx_ready = 1;
    wr_reg(BASE + 0, 7);
    tx_ready = 0;
    rd_reg(BASE + 4, r);
    chk("flush_status", r, 32'h0000_0100);
    rd_reg(BASE + 12, r);
    chk("flush_pending", r, 1);
    nack = 0;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10;
    repeat (4) begin @(negedge clk); if (ack) nack++; end
    @(posedge clk); #1 cyc = 0; stb = 0;
    chk("outside_noack", 32'(nack), 0);

    // 6: async reset mid-drain
    for (int i = 0; i < 4; i++) wr_reg(BASE + 8, 32'(8'h80 + i));
    chk("irq_before_rst", 32'(irq), 1);
    tx_ready = 1;
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("rst_async_valid", 32'(tx_valid), 0);
    chk("rst_async_ack", 32'(ack), 0);
    chk("rst_async_irq", 32'(irq), 0);
    @(posedge clk); #1 rst_n = 1; tx_ready = 0;
    @(posedge clk); #1;
    rd_reg(BASE + 4, r);
    chk("status_after_rst", r, 32'h0000_0100);

    // Randomized traffic checked by the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  rs;
      logic [31:0] d;
      tx_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        cyc = 1; stb = 1; we = 1'($urandom_range(0, 1));
        adr = ($urandom_range(0, 1) != 0) ? BASE + 32'h20 : 32'h4000_0000;
        repeat (2) @(posedge clk);
        #1 cyc = 0; stb = 0;
      end else begin
        rs = 2'($urandom_range(0, 3));
        case (rs)
          2'd0: d = {29'd0, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3))};
          2'd1: d = 32'($urandom_range(0, 1)) << 10;
          2'd2: d = 32'($urandom_range(0, 255));
          default: d = 32'($urandom_range(0, 1));
        endcase
        wb_xfer(1'($urandom_range(0, 1)), BASE + 32'(rs) * 4, d,
                4'($urandom_range(0, 15)), r, lat);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1 tx_ready = 1'($urandom_range(0, 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
